// File: rtl/time_set_controller.sv
// Time-of-day counter with button-driven hour/minute adjustment.
//
// Three operating modes cycle on btn_mode: RUN -> SET_H -> SET_M -> RUN.
// In RUN the once-per-second tick advances hh:mm:ss. In SET_H or SET_M
// time is frozen and btn_inc bumps the selected field. Every output is
// registered, so each response appears one cycle after its input.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      synchronous active-high reset
//   tick       one-cycle pulse, once per second
//   btn_mode   one-cycle pulse, advances the operating mode
//   btn_inc    one-cycle pulse, increments the field under adjustment
//   hours      current hours, 0..HOURS_MOD-1
//   minutes    current minutes, 0..59
//   seconds    current seconds, 0..59
//   mode       00 RUN, 01 SET_H, 10 SET_M
//   blink      display enable for the field under adjustment (1 in RUN)
//   day_pulse  one-cycle pulse when hours wraps to 0 in RUN
module time_set_controller #(
  parameter int unsigned HOURS_MOD = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_pulse
);

  localparam logic [4:0] HourMax = 5'(HOURS_MOD - 1);
  localparam logic [5:0] SixtyMax = 6'd59;

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StSetH = 2'b01,
    StSetM = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;
  logic       blink_q, blink_d;
  logic       day_pulse_q, day_pulse_d;

  always_comb begin
    state_d     = state_q;
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
    blink_d     = blink_q;
    day_pulse_d = 1'b0;

    case (state_q)
      StRun: begin
        blink_d = 1'b1;
        // The tick is applied even when btn_mode leaves RUN in the same cycle.
        if (tick) begin
          if (seconds_q == SixtyMax) begin
            seconds_d = '0;
            if (minutes_q == SixtyMax) begin
              minutes_d = '0;
              if (hours_q == HourMax) begin
                hours_d     = '0;
                day_pulse_d = 1'b1;
              end else begin
                hours_d = hours_q + 5'd1;
              end
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end
        if (btn_mode) begin
          state_d = StSetH;
        end
      end

      StSetH: begin
        if (btn_mode) begin
          // Mode change wins over btn_inc; entering a SET state re-lights blink.
          state_d = StSetM;
          blink_d = 1'b1;
        end else begin
          if (btn_inc) begin
            hours_d = (hours_q == HourMax) ? '0 : hours_q + 5'd1;
          end
          if (tick) begin
            blink_d = ~blink_q;
          end
        end
      end

      StSetM: begin
        if (btn_mode) begin
          state_d   = StRun;
          blink_d   = 1'b1;
          seconds_d = '0;
        end else begin
          // Minutes wrap without carrying into hours.
          if (btn_inc) begin
            minutes_d = (minutes_q == SixtyMax) ? '0 : minutes_q + 6'd1;
          end
          if (tick) begin
            blink_d = ~blink_q;
          end
        end
      end

      default: begin
        state_d = StRun;
        blink_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      hours_q     <= '0;
      minutes_q   <= '0;
      seconds_q   <= '0;
      blink_q     <= 1'b1;
      day_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      blink_q     <= blink_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign hours     = hours_q;
  assign minutes   = minutes_q;
  assign seconds   = seconds_q;
  assign mode      = state_q;
  assign blink     = blink_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller. A seconds-of-day reference
// model tracks expected outputs every cycle; directed scenarios add
// explicit checks against hand-computed constants.
module tb_time_set_controller;

  localparam int unsigned HOURS_MOD = 24;
  localparam int DaySecs = HOURS_MOD * 3600;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blink;
  logic       day_pulse;

  int tests = 0;
  int fails = 0;

  // Reference model: time kept as seconds since midnight.
  int m_secs = 0;
  int m_mode = 0;  // 0 run, 1 set hours, 2 set minutes
  bit m_blink = 1'b1;
  bit m_day = 1'b0;
  bit model_valid = 1'b0;

  time_set_controller #(.HOURS_MOD(HOURS_MOD)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .mode     (mode),
    .blink    (blink),
    .day_pulse(day_pulse)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit t, input bit bm, input bit bi);
    int h, mi;
    if (r) begin
      m_secs = 0; m_mode = 0; m_blink = 1'b1; m_day = 1'b0; model_valid = 1'b1;
      return;
    end
    m_day = 1'b0;
    h  = m_secs / 3600;
    mi = (m_secs / 60) % 60;
    case (m_mode)
      0: begin
        if (t) begin
          m_secs = (m_secs + 1) % DaySecs;
          m_day  = (m_secs == 0);
        end
        if (bm) m_mode = 1;
        m_blink = 1'b1;
      end
      1: begin
        if (bm) begin
          m_mode = 2; m_blink = 1'b1;
        end else begin
          if (bi) m_secs = ((h + 1) % HOURS_MOD) * 3600 + (m_secs % 3600);
          if (t) m_blink = !m_blink;
        end
      end
      default: begin
        if (bm) begin
          m_mode = 0; m_blink = 1'b1; m_secs = m_secs - (m_secs % 60);
        end else begin
          if (bi) m_secs = m_secs - mi * 60 + ((mi + 1) % 60) * 60;
          if (t) m_blink = !m_blink;
        end
      end
    endcase
  endtask

  task automatic model_check();
    if (!model_valid) return;
    chk("model_hours", 32'(hours), 32'(m_secs / 3600));
    chk("model_minutes", 32'(minutes), 32'((m_secs / 60) % 60));
    chk("model_seconds", 32'(seconds), 32'(m_secs % 60));
    chk("model_mode", 32'(mode), 32'(m_mode));
    chk("model_blink", 32'(blink), 32'(m_blink));
    chk("model_day_pulse", 32'(day_pulse), 32'(m_day));
  endtask

  // One clock cycle with the given inputs; checks against the model #1 after the edge.
  task automatic step(input bit r, input bit t, input bit bm, input bit bi);
    reset = r; tick = t; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_update(r, t, bm, bi);
    #1;
    reset = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    model_check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic expect_time(input string tag, input int h, input int mi, input int s);
    chk({tag, "_h"}, 32'(hours), 32'(h));
    chk({tag, "_m"}, 32'(minutes), 32'(mi));
    chk({tag, "_s"}, 32'(seconds), 32'(s));
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    expect_time("reset", 0, 0, 0);
    chk("reset_mode", 32'(mode), 32'd0);
    chk("reset_blink", 32'(blink), 32'd1);
    chk("reset_day", 32'(day_pulse), 32'd0);

    // Free run: 60 ticks then 3600 total
    ticks(60);
    expect_time("run60", 0, 1, 0);
    ticks(3540);
    expect_time("run3600", 1, 0, 0);

    // Set sequence from 00:00:07
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(7);
    expect_time("pre_set", 0, 0, 7);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("set_h_mode", 32'(mode), 32'd1);
    chk("set_h_blink", 32'(blink), 32'd1);
    incs(5);
    chk("set_h_hours", 32'(hours), 32'd5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(3);
    chk("set_m_minutes", 32'(minutes), 32'd3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("set_done_mode", 32'(mode), 32'd0);
    expect_time("set_done", 5, 3, 0);

    // Day rollover from 23:59:59
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(18);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(56);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(59);
    expect_time("pre_roll", 23, 59, 59);
    chk("pre_roll_day", 32'(day_pulse), 32'd0);
    ticks(1);
    expect_time("roll", 0, 0, 0);
    chk("roll_day", 32'(day_pulse), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("roll_day_off", 32'(day_pulse), 32'd0);

    // Minute wrap without carry, frozen seconds, blink toggling
    ticks(5);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(7);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(59);
    expect_time("m59", 7, 59, 5);
    incs(1);
    expect_time("m_wrap", 7, 0, 5);
    ticks(1);
    chk("blink_t1", 32'(blink), 32'd0);
    chk("frozen_s1", 32'(seconds), 32'd5);
    ticks(1);
    chk("blink_t2", 32'(blink), 32'd1);
    ticks(1);
    chk("blink_t3", 32'(blink), 32'd0);
    chk("frozen_s3", 32'(seconds), 32'd5);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("inc_tick_min", 32'(minutes), 32'd1);
    chk("inc_tick_blink", 32'(blink), 32'd1);

    // Simultaneous btn_mode + btn_inc in SET_H with hours=4
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_time("exit_m", 7, 1, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(21);
    chk("h_wrap_4", 32'(hours), 32'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("mode_inc_mode", 32'(mode), 32'd2);
    chk("mode_inc_hours", 32'(hours), 32'd4);

    // Simultaneous btn_mode + tick in RUN at 00:00:59
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(59);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    expect_time("mode_tick", 0, 1, 0);
    chk("mode_tick_mode", 32'(mode), 32'd1);

    // Reset mid-adjustment in SET_M at 12:34:56
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(12);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    incs(34);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(56);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expect_time("pre_mid_rst", 12, 34, 56);
    chk("pre_mid_rst_mode", 32'(mode), 32'd2);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    expect_time("mid_rst", 0, 0, 0);
    chk("mid_rst_mode", 32'(mode), 32'd0);
    chk("mid_rst_blink", 32'(blink), 32'd1);
    chk("mid_rst_day", 32'(day_pulse), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
